// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Ports: clk, rst (sync active-low); PCSrcE/PCTargetE redirect from execute;
//   StallF/StallD/FlushD from hazard unit; ImemAddr/ImemRdata combinational
//   instruction memory; InstrD/PCD/PCPlus4D/ValidD to decode; MisalignF pulse.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [31:0] ImemRdata,
    output logic [31:0] ImemAddr,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignF
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] r_pcf;
    logic [31:0] r_instrd;
    logic [31:0] r_pcd;
    logic [31:0] r_pcplus4d;
    logic        r_validd;
    logic        r_misalign;

    logic [31:0] w_pcplus4f;
    logic [31:0] w_pcnext;
    logic        w_bubble;

    assign w_pcplus4f = r_pcf + 32'd4;
    // Low target bits are dropped; the misalignment is only reported.
    assign w_pcnext   = PCSrcE ? {PCTargetE[31:2], 2'b00} : w_pcplus4f;
    // A redirect squashes the wrong-path instruction currently in fetch.
    assign w_bubble   = FlushD | PCSrcE;

    // A redirect overrides StallF so a taken branch is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pcf <= 32'h0000_0000;
        end else if (PCSrcE || !StallF) begin
            r_pcf <= w_pcnext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_bubble) begin
            r_instrd   <= NOP;
            r_pcd      <= 32'h0000_0000;
            r_pcplus4d <= 32'h0000_0000;
            r_validd   <= 1'b0;
        end else if (!StallD) begin
            r_instrd   <= ImemRdata;
            r_pcd      <= r_pcf;
            r_pcplus4d <= w_pcplus4f;
            r_validd   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= PCSrcE & (|PCTargetE[1:0]);
        end
    end

    assign ImemAddr  = r_pcf;
    assign InstrD    = r_instrd;
    assign PCD       = r_pcd;
    assign PCPlus4D  = r_pcplus4d;
    assign ValidD    = r_validd;
    assign MisalignF = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vectors, per-cycle behavioural model
// compare, plus literal expectations at key points.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] ImemRdata;
    logic [31:0] ImemAddr;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignF;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .ImemRdata (ImemRdata),
        .ImemAddr  (ImemAddr),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .MisalignF (MisalignF)
    );

    // Instruction memory: word i holds 0x1000 + i.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h1000 + (a / 4);
    endfunction

    assign ImemRdata = imem(ImemAddr);

    // Behavioural model of the architectural state.
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_pcd;
    logic [31:0] m_p4d;
    logic        m_v;
    logic        m_mis;
    logic        m_known = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_pc    = 0;
            m_ins   = NOP;
            m_pcd   = 0;
            m_p4d   = 0;
            m_v     = 0;
            m_mis   = 0;
            m_known = 1;
        end else if (m_known) begin
            m_mis = PCSrcE && (PCTargetE % 4 != 0);
            if (FlushD || PCSrcE) begin
                m_ins = NOP;
                m_pcd = 0;
                m_p4d = 0;
                m_v   = 0;
            end else if (!StallD) begin
                m_ins = imem(m_pc);
                m_pcd = m_pc;
                m_p4d = m_pc + 4;
                m_v   = 1;
            end
            if (PCSrcE)
                m_pc = PCTargetE - (PCTargetE % 4);
            else if (!StallF)
                m_pc = m_pc + 4;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("m_addr",  ImemAddr,          m_pc);
            chk("m_instr", InstrD,            m_ins);
            chk("m_pcd",   PCD,               m_pcd);
            chk("m_pc4d",  PCPlus4D,          m_p4d);
            chk("m_valid", {31'd0, ValidD},   {31'd0, m_v});
            chk("m_mis",   {31'd0, MisalignF}, {31'd0, m_mis});
        end
    end

    task automatic drive(input logic src, input logic [31:0] tgt,
                         input logic sf, input logic sd, input logic fd);
        PCSrcE    = src;
        PCTargetE = tgt;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_addr",  ImemAddr, 32'h0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        chk("rst_mis",   {31'd0, MisalignF}, 32'd0);

        // Free-running fetch after reset.
        rst = 1'b1;
        tick();
        chk("e1_addr",  ImemAddr, 32'h4);
        chk("e1_instr", InstrD, 32'h1000);
        chk("e1_pcd",   PCD, 32'h0);
        chk("e1_pc4d",  PCPlus4D, 32'h4);
        chk("e1_valid", {31'd0, ValidD}, 32'd1);
        tick();
        chk("e2_instr", InstrD, 32'h1001);
        tick();
        chk("e3_addr",  ImemAddr, 32'hC);
        chk("e3_instr", InstrD, 32'h1002);

        // Redirect from 0x20 to 0x100.
        drive(1, 32'h20, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("pre_br_addr", ImemAddr, 32'h24);
        drive(1, 32'h100, 0, 0, 0);
        tick();
        chk("br_addr",  ImemAddr, 32'h100);
        chk("br_instr", InstrD, NOP);
        chk("br_valid", {31'd0, ValidD}, 32'd0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("br_pcd",   PCD, 32'h100);
        chk("br_ins2",  InstrD, 32'h1040);

        // Stall both at PCF=0x40 for two edges.
        drive(1, 32'h3C, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("st0_addr", ImemAddr, 32'h40);
        chk("st0_pcd",  PCD, 32'h3C);
        drive(0, 0, 1, 1, 0);
        tick();
        tick();
        chk("st_addr",  ImemAddr, 32'h40);
        chk("st_instr", InstrD, 32'h100F);
        chk("st_pcd",   PCD, 32'h3C);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("rel_addr",  ImemAddr, 32'h44);
        chk("rel_instr", InstrD, 32'h1010);
        chk("rel_pcd",   PCD, 32'h40);

        // Misaligned redirect during StallF.
        drive(1, 32'h203, 1, 0, 0);
        tick();
        chk("mis_addr", ImemAddr, 32'h200);
        chk("mis_on",   {31'd0, MisalignF}, 32'd1);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("mis_off",  {31'd0, MisalignF}, 32'd0);
        chk("mis_pcd",  PCD, 32'h200);

        // StallF without StallD duplicates the same PC.
        drive(0, 0, 1, 0, 0);
        tick();
        tick();
        chk("dup_addr", ImemAddr, 32'h204);
        chk("dup_pcd",  PCD, 32'h204);
        chk("dup_ins",  InstrD, 32'h1081);

        // Flush and StallD together: flush wins.
        drive(0, 0, 0, 1, 1);
        tick();
        chk("fl_valid", {31'd0, ValidD}, 32'd0);
        chk("fl_instr", InstrD, NOP);
        chk("fl_addr",  ImemAddr, 32'h208);

        // PC wrap at the top of the address space.
        drive(1, 32'hFFFF_FFFC, 0, 0, 0);
        tick();
        chk("wr_addr0", ImemAddr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("wr_addr",  ImemAddr, 32'h0);
        chk("wr_pc4d",  PCPlus4D, 32'h0);
        chk("wr_pcd",   PCD, 32'hFFFF_FFFC);
        chk("wr_instr", InstrD, 32'h4000_0FFF);

        // Reset overrides everything on the same edge.
        rst = 1'b0;
        drive(1, 32'h7, 1, 1, 0);
        tick();
        chk("rr_addr",  ImemAddr, 32'h0);
        chk("rr_instr", InstrD, NOP);
        chk("rr_valid", {31'd0, ValidD}, 32'd0);
        chk("rr_pcd",   PCD, 32'h0);
        chk("rr_mis",   {31'd0, MisalignF}, 32'd0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        chk("rr2_addr",  ImemAddr, 32'h4);
        chk("rr2_instr", InstrD, 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
